// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep checker.
// Build option: define STOP_ON_FAIL_EN to end a sweep on its first mismatch.
package tt_sweep_pkg;

  typedef logic [1:0] tt_state_t;

  localparam tt_state_t ST_IDLE  = 2'd0;
  localparam tt_state_t ST_APPLY = 2'd1;
  localparam tt_state_t ST_DONE  = 2'd2;

  // Expected table of F = ~x & y with vec = {x, y, z}.
  localparam logic [7:0] TT_EXP_TT_DEFAULT = 8'b0000_1100;

  // The hold counter needs at least one bit, even when HOLD == 1.
  function automatic int tt_hold_w(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/tt_hold_timer.sv
// Counts the cycles a sweep vector is held; last marks the sampling cycle.
module tt_hold_timer
  import tt_sweep_pkg::*;
#(
  parameter int HOLD = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int W = tt_hold_w(HOLD);
  localparam logic [W-1:0] LAST_CNT = W'(HOLD - 1);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state is written with <= so every flop samples the
  // values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (en) begin
      if (r_cnt == LAST_CNT) r_cnt <= '0;
      else                   r_cnt <= r_cnt + 1'b1;
    end
  end

  assign last = (r_cnt == LAST_CNT);

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all input vectors of an N_IN-input combinational DUT and scores its
// response against EXP_TT. Build option: STOP_ON_FAIL_EN (stop at first mismatch).
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int                  N_IN   = 3,
  parameter int                  HOLD   = 3,
  parameter logic [(1<<N_IN)-1:0] EXP_TT = TT_EXP_TT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  f_in,
  output logic [N_IN-1:0]       vec,
  output logic                  vec_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_IN:0]         mismatch_cnt,
  output logic [N_IN-1:0]       first_fail_vec,
  output logic                  fail_seen,
  output logic [(1<<N_IN)-1:0]  tt_captured
);

  localparam int              N_VEC   = 1 << N_IN;
  localparam logic [N_IN-1:0] VEC_MAX = '1;

  tt_state_t             r_state;
  logic [N_IN-1:0]       r_vec;
  logic [N_IN:0]         r_mismatch_cnt;
  logic [N_IN-1:0]       r_first_fail_vec;
  logic                  r_fail_seen;
  logic                  r_pass;
  logic [N_VEC-1:0]      r_tt;

  logic                  w_apply;
  logic                  w_last;
  logic                  w_sample;
  logic                  w_bad;
  logic                  w_final;
  logic [N_IN:0]         w_mm_next;

  assign w_apply  = (r_state == ST_APPLY);
  assign w_sample = w_apply && w_last;
  assign w_bad    = w_sample && (f_in != EXP_TT[r_vec]);
  assign w_mm_next = r_mismatch_cnt + {{N_IN{1'b0}}, w_bad};

`ifdef STOP_ON_FAIL_EN
  assign w_final = w_sample && ((r_vec == VEC_MAX) || w_bad);
`else
  assign w_final = w_sample && (r_vec == VEC_MAX);
`endif

  // Timer is held at zero outside APPLY, so each sweep starts on a clean count.
  tt_hold_timer #(.HOLD(HOLD)) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (!w_apply),
    .en    (w_apply),
    .last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_vec            <= '0;
      r_mismatch_cnt   <= '0;
      r_first_fail_vec <= '0;
      r_fail_seen      <= 1'b0;
      r_pass           <= 1'b0;
      r_tt             <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state          <= ST_APPLY;
            r_vec            <= '0;
            r_mismatch_cnt   <= '0;
            r_first_fail_vec <= '0;
            r_fail_seen      <= 1'b0;
            r_pass           <= 1'b0;
            r_tt             <= '0;
          end
        end

        ST_APPLY: begin
          if (w_sample) begin
            r_tt[r_vec]    <= f_in;
            r_mismatch_cnt <= w_mm_next;
            if (w_bad && !r_fail_seen) begin
              r_first_fail_vec <= r_vec;
              r_fail_seen      <= 1'b1;
            end
            // pass uses the count including this final sample.
            if (w_final) begin
              r_state <= ST_DONE;
              r_pass  <= (w_mm_next == '0);
            end else begin
              r_vec <= r_vec + 1'b1;
            end
          end
        end

        ST_DONE: r_state <= ST_IDLE;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign vec            = r_vec;
  assign vec_valid      = w_apply;
  assign busy           = w_apply;
  assign done           = (r_state == ST_DONE);
  assign pass           = r_pass;
  assign mismatch_cnt   = r_mismatch_cnt;
  assign first_fail_vec = r_first_fail_vec;
  assign fail_seen      = r_fail_seen;
  assign tt_captured    = r_tt;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench: default 3-input checker plus a 4-input XOR instance.
module tb_tt_sweep_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start4 = 1'b0;
  int         f_mode = 0;   // 0: F=~x&y, 1: tied 0, 2: tied 1

  logic [2:0] vec;
  logic       vec_valid, busy, done, pass, fail_seen;
  logic [3:0] mismatch_cnt;
  logic [2:0] first_fail_vec;
  logic [7:0] tt_captured;
  logic       f_in;

  logic [3:0]  vec4;
  logic        vec_valid4, busy4, done4, pass4, fail_seen4;
  logic [4:0]  mismatch_cnt4;
  logic [3:0]  first_fail_vec4;
  logic [15:0] tt_captured4;
  logic        f_in4;

  int n_checks = 0;
  int n_fail   = 0;
  int n;
  int dn;

  always #5 clk = ~clk;

  assign f_in  = (f_mode == 0) ? (~vec[2] & vec[1]) : (f_mode == 2);
  assign f_in4 = ^vec4;

  tt_sweep_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .f_in(f_in),
    .vec(vec), .vec_valid(vec_valid), .busy(busy), .done(done), .pass(pass),
    .mismatch_cnt(mismatch_cnt), .first_fail_vec(first_fail_vec),
    .fail_seen(fail_seen), .tt_captured(tt_captured)
  );

  tt_sweep_checker #(.N_IN(4), .HOLD(1), .EXP_TT(16'h6996)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .f_in(f_in4),
    .vec(vec4), .vec_valid(vec_valid4), .busy(busy4), .done(done4), .pass(pass4),
    .mismatch_cnt(mismatch_cnt4), .first_fail_vec(first_fail_vec4),
    .fail_seen(fail_seen4), .tt_captured(tt_captured4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Pulse start for one edge; returns with the accepting edge just passed.
  task automatic pulse_start(input bit sel4);
    @(negedge clk);
    if (sel4) start4 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    start4 = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen.
  task automatic wait_done(input bit sel4, input int budget, output int edges);
    edges = 0;
    while (1) begin
      @(posedge clk); #1;
      edges++;
      if (sel4 ? done4 : done) break;
      if (edges >= budget) begin
        check("done_timeout", 32'(edges), 32'(budget + 1));
        break;
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  32'(busy), 0);
    check("rst_valid", 32'(vec_valid), 0);
    check("rst_done",  32'(done), 0);
    check("rst_pass",  32'(pass), 0);
    check("rst_vec",   32'(vec), 0);
    check("rst_cnt",   32'(mismatch_cnt), 0);
    check("rst_ffv",   32'(first_fail_vec), 0);
    check("rst_fseen", 32'(fail_seen), 0);
    check("rst_tt",    32'(tt_captured), 0);
    rst = 1'b0;

    // Test 1: matching DUT, latency 25 cycles counting the start cycle.
    f_mode = 0;
    pulse_start(0);
    check("t1_busy", 32'(busy), 1);
    check("t1_valid", 32'(vec_valid), 1);
    wait_done(0, 100, n);
    check("t1_latency", 32'(n + 1), 25);
    check("t1_valid_done", 32'(vec_valid), 0);
    check("t1_busy_done",  32'(busy), 0);
    check("t1_vec_hold",   32'(vec), 7);
    @(posedge clk); #1;
    check("t1_done_pulse", 32'(done), 0);
    check("t1_tt",    32'(tt_captured), 32'h0C);
    check("t1_cnt",   32'(mismatch_cnt), 0);
    check("t1_pass",  32'(pass), 1);
    check("t1_fseen", 32'(fail_seen), 0);

    // Test 2 (default) / Test 5 (stop-on-fail build).
    f_mode = 1;
    pulse_start(0);
    check("t2_pass_cleared", 32'(pass), 0);
    wait_done(0, 100, n);
    @(posedge clk); #1;
`ifdef STOP_ON_FAIL_EN
    check("t2s_latency", 32'(n + 1), 10);
    check("t2s_cnt",     32'(mismatch_cnt), 1);
`else
    check("t2_latency",  32'(n + 1), 25);
    check("t2_cnt",      32'(mismatch_cnt), 2);
`endif
    check("t2_ffv",   32'(first_fail_vec), 2);
    check("t2_fseen", 32'(fail_seen), 1);
    check("t2_pass",  32'(pass), 0);
    check("t2_tt",    32'(tt_captured), 0);

`ifdef STOP_ON_FAIL_EN
    // Test 5: f_in tied 1 fails at vec 0.
    f_mode = 2;
    pulse_start(0);
    wait_done(0, 100, n);
    check("t5_latency", 32'(n + 1), 4);
    @(posedge clk); #1;
    check("t5_ffv",  32'(first_fail_vec), 0);
    check("t5_cnt",  32'(mismatch_cnt), 1);
    check("t5_pass", 32'(pass), 0);
    check("t5_tt",   32'(tt_captured), 32'h01);
`endif

    // Test 3: reset while vec == 4, then a clean sweep.
    f_mode = 0;
    pulse_start(0);
    n = 0;
    while (!(busy && vec == 3'd4) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t3_reached_vec4", 32'(vec), 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t3_busy", 32'(busy), 0);
    check("t3_vec",  32'(vec), 0);
    check("t3_cnt",  32'(mismatch_cnt), 0);
    check("t3_done", 32'(done), 0);
    check("t3_tt",   32'(tt_captured), 0);
    pulse_start(0);
    wait_done(0, 100, n);
    check("t3_latency", 32'(n + 1), 25);
    @(posedge clk); #1;
    check("t3_pass", 32'(pass), 1);

    // Test 4: start held for 30 edges.
    dn = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
      if (i == 12) check("t4_no_restart_vec", 32'(vec), 4);
      if (i == 24) check("t4_done_at_24", 32'(done), 1);
      if (i == 25) check("t4_idle_gap", 32'(busy), 0);
      if (i == 26) begin
        check("t4_restart", 32'(busy), 1);
        check("t4_restart_vec", 32'(vec), 0);
      end
    end
    start = 1'b0;
    check("t4_one_done", 32'(dn), 1);
    wait_done(0, 100, n);
    check("t4_second_done", 32'(n), 21);
    @(posedge clk); #1;
    check("t4_pass", 32'(pass), 1);

    // Test 6: 4-input XOR, HOLD=1.
    pulse_start(1);
    check("t6_busy", 32'(busy4), 1);
    wait_done(1, 100, n);
    check("t6_latency", 32'(n + 1), 17);
    @(posedge clk); #1;
    check("t6_pass", 32'(pass4), 1);
    check("t6_tt",   32'(tt_captured4), 32'h6996);
    check("t6_cnt",  32'(mismatch_cnt4), 0);
    check("t6_fseen", 32'(fail_seen4), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
